// File: rtl/ascon_perm_engine.sv
// ---------------------------------------------------------------------------
// ascon_perm_engine
// Iterative Ascon permutation engine over a 320-bit state (five 64-bit words).
// The state is loaded and read back one word at a time while the engine is
// idle. A start request runs the last n rounds of the 12-round schedule
// (round constants 12-n .. 11), UNROLL rounds per clock.
//
// Optional build macro:
//   ASCON_PERM_FULL_STATE_EN - adds output state_o (320 bits, word 0 in the
//                              LSBs) mirroring the state register.
// ---------------------------------------------------------------------------
module ascon_perm_engine #(
  parameter int UNROLL = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_i,
  input  logic [3:0]   rounds_i,
  input  logic [2:0]   word_sel_i,
  input  logic [63:0]  data_i,
  input  logic         write_en_i,
  input  logic         xor_en_i,
  output logic [63:0]  data_o,
  output logic         ready_o,
  output logic         done_o,
  output logic         err_o
`ifdef ASCON_PERM_FULL_STATE_EN
  ,
  output logic [319:0] state_o
`endif
);

  // Only 1..4 rounds per cycle are supported by the unrolled datapath.
  if ((UNROLL < 1) || (UNROLL > 4)) begin : g_bad_unroll
    $error("ascon_perm_engine: UNROLL must be in the range 1..4");
  end

  localparam logic [3:0] UNROLL_W = 4'(UNROLL);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_PERM = 1'b1
  } fsm_e;

  // 64-bit rotate right by a constant amount.
  function automatic logic [63:0] ror64(input logic [63:0] x, input int unsigned sh);
    ror64 = (x >> sh) | (x << (64 - sh));
  endfunction

  // One full Ascon round: constant addition, bitsliced S-box, linear layer.
  function automatic logic [319:0] ascon_round(input logic [319:0] s, input logic [3:0] idx);
    logic [63:0] x0, x1, x2, x3, x4;
    logic [63:0] t0, t1, t2, t3, t4;
    x0 = s[63:0];
    x1 = s[127:64];
    x2 = s[191:128];
    x3 = s[255:192];
    x4 = s[319:256];
    // Round constant for round idx: high nibble 0xF-idx, low nibble idx.
    x2 = x2 ^ {56'd0, (4'hF - idx), idx};
    // Substitution layer, 64 parallel 5-bit S-boxes.
    x0 = x0 ^ x4;
    x4 = x4 ^ x3;
    x2 = x2 ^ x1;
    t0 = ~x0 & x1;
    t1 = ~x1 & x2;
    t2 = ~x2 & x3;
    t3 = ~x3 & x4;
    t4 = ~x4 & x0;
    x0 = x0 ^ t1;
    x1 = x1 ^ t2;
    x2 = x2 ^ t3;
    x3 = x3 ^ t4;
    x4 = x4 ^ t0;
    x1 = x1 ^ x0;
    x0 = x0 ^ x4;
    x3 = x3 ^ x2;
    x2 = ~x2;
    // Linear diffusion layer.
    x0 = x0 ^ ror64(x0, 19) ^ ror64(x0, 28);
    x1 = x1 ^ ror64(x1, 61) ^ ror64(x1, 39);
    x2 = x2 ^ ror64(x2, 1)  ^ ror64(x2, 6);
    x3 = x3 ^ ror64(x3, 10) ^ ror64(x3, 17);
    x4 = x4 ^ ror64(x4, 7)  ^ ror64(x4, 41);
    ascon_round = {x4, x3, x2, x1, x0};
  endfunction

  fsm_e              fsm_q, fsm_d;
  logic [4:0][63:0]  state_q, state_d;
  logic [3:0]        r_q, r_d;
  logic [3:0]        m_q, m_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              rounds_ok_s;
  logic              last_s;
  logic [3:0]        k_s;
  logic [3:0]        en_s;
  logic [319:0]      st1_s, st2_s, st3_s, st4_s;
  logic [63:0]       wr_word_s;

  assign rounds_ok_s = (rounds_i != 4'd0) && (rounds_i <= 4'd12);
  assign last_s      = (m_q <= UNROLL_W);
  assign k_s         = (m_q < UNROLL_W) ? m_q : UNROLL_W;

  // Stage j is live only when j < min(UNROLL, m); later stages pass through.
  assign en_s[0] = (4'd0 < k_s);
  assign en_s[1] = (4'd1 < k_s);
  assign en_s[2] = (4'd2 < k_s);
  assign en_s[3] = (4'd3 < k_s);

  assign st1_s = en_s[0] ? ascon_round(state_q, r_q)         : state_q;
  assign st2_s = en_s[1] ? ascon_round(st1_s, r_q + 4'd1)    : st1_s;
  assign st3_s = en_s[2] ? ascon_round(st2_s, r_q + 4'd2)    : st2_s;
  assign st4_s = en_s[3] ? ascon_round(st3_s, r_q + 4'd3)    : st3_s;

  // data_o already holds word[word_sel_i] (or 0), which is the XOR operand.
  assign wr_word_s = xor_en_i ? (data_o ^ data_i) : data_i;

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q <= S_IDLE;
    end else begin
      fsm_q <= fsm_d;
    end
  end

  // FSM next-state: leave IDLE on a legal start, leave PERM on the last batch.
  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      S_IDLE: begin
        if (start_i && rounds_ok_s) begin
          fsm_d = S_PERM;
        end else begin
          fsm_d = S_IDLE;
        end
      end
      S_PERM: begin
        if (last_s) begin
          fsm_d = S_IDLE;
        end else begin
          fsm_d = S_PERM;
        end
      end
      default: begin
        fsm_d = S_IDLE;
      end
    endcase
  end

  // FSM outputs and datapath next-state: host writes/start in IDLE, rounds in PERM.
  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    m_d     = m_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (fsm_q)
      S_IDLE: begin
        if (write_en_i) begin
          case (word_sel_i)
            3'd0:    state_d[0] = wr_word_s;
            3'd1:    state_d[1] = wr_word_s;
            3'd2:    state_d[2] = wr_word_s;
            3'd3:    state_d[3] = wr_word_s;
            3'd4:    state_d[4] = wr_word_s;
            default: state_d    = state_q;
          endcase
        end else begin
          state_d = state_q;
        end
        if (start_i) begin
          if (rounds_ok_s) begin
            r_d = 4'd12 - rounds_i;
            m_d = rounds_i;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          r_d = r_q;
          m_d = m_q;
        end
      end
      S_PERM: begin
        state_d = st4_s;
        r_d     = r_q + k_s;
        m_d     = m_q - k_s;
        done_d  = last_s;
      end
      default: begin
        state_d = state_q;
      end
    endcase
  end

  // Moore output: ready while idle.
  always_comb begin
    if (fsm_q == S_IDLE) begin
      ready_o = 1'b1;
    end else begin
      ready_o = 1'b0;
    end
  end

  // Datapath registers and registered status pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= '0;
      r_q     <= 4'd0;
      m_q     <= 4'd0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      m_q     <= m_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Word readback; indices beyond the state read as zero.
  always_comb begin
    case (word_sel_i)
      3'd0:    data_o = state_q[0];
      3'd1:    data_o = state_q[1];
      3'd2:    data_o = state_q[2];
      3'd3:    data_o = state_q[3];
      3'd4:    data_o = state_q[4];
      default: data_o = 64'd0;
    endcase
  end

  assign done_o = done_q;
  assign err_o  = err_q;

`ifdef ASCON_PERM_FULL_STATE_EN
  assign state_o = state_q;
`endif

endmodule

// File: tb/tb_ascon_perm_engine.sv
// ---------------------------------------------------------------------------
// tb_ascon_perm_engine
// Directed bench driving three engines (UNROLL = 1, 3, 4) with shared data
// and per-engine start/write strobes. Expected states come from a table-
// driven software model of the Ascon round.
// ---------------------------------------------------------------------------
module tb_ascon_perm_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  start_v = 3'b000;
  logic [2:0]  we_v = 3'b000;
  logic [3:0]  rounds = 4'd0;
  logic [2:0]  word_sel = 3'd0;
  logic [63:0] data = 64'd0;
  logic        xor_en = 1'b0;
  logic [63:0] dout [3];
  logic [2:0]  ready_v, done_v, err_v;
`ifdef ASCON_PERM_FULL_STATE_EN
  logic [319:0] st [3];
`endif

  logic [319:0] mdl [3];
  int checks = 0;
  int errors = 0;

  localparam logic [4:0] SBOX_T [0:31] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
  };

  always #10 clk = ~clk;

  ascon_perm_engine #(.UNROLL(1)) u_d1 (
    .clk(clk), .rst(rst), .start_i(start_v[0]), .rounds_i(rounds),
    .word_sel_i(word_sel), .data_i(data), .write_en_i(we_v[0]), .xor_en_i(xor_en),
    .data_o(dout[0]), .ready_o(ready_v[0]), .done_o(done_v[0]), .err_o(err_v[0])
`ifdef ASCON_PERM_FULL_STATE_EN
    , .state_o(st[0])
`endif
  );

  ascon_perm_engine #(.UNROLL(3)) u_d3 (
    .clk(clk), .rst(rst), .start_i(start_v[1]), .rounds_i(rounds),
    .word_sel_i(word_sel), .data_i(data), .write_en_i(we_v[1]), .xor_en_i(xor_en),
    .data_o(dout[1]), .ready_o(ready_v[1]), .done_o(done_v[1]), .err_o(err_v[1])
`ifdef ASCON_PERM_FULL_STATE_EN
    , .state_o(st[1])
`endif
  );

  ascon_perm_engine #(.UNROLL(4)) u_d4 (
    .clk(clk), .rst(rst), .start_i(start_v[2]), .rounds_i(rounds),
    .word_sel_i(word_sel), .data_i(data), .write_en_i(we_v[2]), .xor_en_i(xor_en),
    .data_o(dout[2]), .ready_o(ready_v[2]), .done_o(done_v[2]), .err_o(err_v[2])
`ifdef ASCON_PERM_FULL_STATE_EN
    , .state_o(st[2])
`endif
  );

  function automatic logic [63:0] rotr(input logic [63:0] a, input int n);
    logic [127:0] d;
    d = {a, a};
    return d[n +: 64];
  endfunction

  // Software model: rounds first..first+count-1, S-box applied column by column.
  function automatic logic [319:0] model_rounds(input logic [319:0] s, input int first, input int count);
    logic [63:0] x [5];
    logic [63:0] y [5];
    logic [4:0]  col, v;
    logic [319:0] res;
    for (int w = 0; w < 5; w++) x[w] = s[w*64 +: 64];
    for (int r = first; r < first + count; r++) begin
      x[2] = x[2] ^ 64'((15 - r) * 16 + r);
      for (int b = 0; b < 64; b++) begin
        col = {x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]};
        v = SBOX_T[col];
        y[0][b] = v[4]; y[1][b] = v[3]; y[2][b] = v[2]; y[3][b] = v[1]; y[4][b] = v[0];
      end
      x[0] = y[0] ^ rotr(y[0], 19) ^ rotr(y[0], 28);
      x[1] = y[1] ^ rotr(y[1], 61) ^ rotr(y[1], 39);
      x[2] = y[2] ^ rotr(y[2], 1)  ^ rotr(y[2], 6);
      x[3] = y[3] ^ rotr(y[3], 10) ^ rotr(y[3], 17);
      x[4] = y[4] ^ rotr(y[4], 7)  ^ rotr(y[4], 41);
    end
    for (int w = 0; w < 5; w++) res[w*64 +: 64] = x[w];
    return res;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all_words(input string tag);
    @(negedge clk);
    for (int s = 0; s < 5; s++) begin
      word_sel = 3'(s);
      #1;
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("%s u%0d w%0d", tag, i, s), dout[i], mdl[i][s*64 +: 64]);
`ifdef ASCON_PERM_FULL_STATE_EN
        chk($sformatf("%s state_o u%0d w%0d", tag, i, s), st[i][s*64 +: 64], mdl[i][s*64 +: 64]);
`endif
      end
    end
    word_sel = 3'd5;
    #1;
    for (int i = 0; i < 3; i++) chk($sformatf("%s u%0d w5", tag, i), dout[i], 64'd0);
  endtask

  task automatic write_word(input logic [2:0] mask, input logic [2:0] sel, input logic [63:0] val, input logic xorv);
    @(negedge clk);
    we_v = mask; word_sel = sel; data = val; xor_en = xorv;
    @(posedge clk);
    #1;
    we_v = 3'b000; xor_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (mask[i] && (sel <= 3'd4)) begin
        if (xorv) mdl[i][sel*64 +: 64] = mdl[i][sel*64 +: 64] ^ val;
        else      mdl[i][sel*64 +: 64] = val;
      end
    end
  endtask

  // Start (optionally with a same-cycle write), then watch 16 cycles for done pulses.
  task automatic start_and_wait(input string tag, input logic [2:0] smask, input logic [3:0] n,
                                input int e0, input int e1, input int e2,
                                input logic [2:0] wmask, input logic [2:0] wsel, input logic [63:0] wdata);
    int lat [3];
    int pulses [3];
    int ex [3];
    logic [319:0] pre0, mid0;
    ex[0] = e0; ex[1] = e1; ex[2] = e2;
    @(negedge clk);
    start_v = smask; rounds = n; we_v = wmask; word_sel = wsel; data = wdata; xor_en = 1'b0;
    for (int i = 0; i < 3; i++) if (wmask[i]) mdl[i][wsel*64 +: 64] = wdata;
    pre0 = mdl[0];
    mid0 = model_rounds(pre0, 12 - int'(n), 1);
    @(posedge clk);
    #1;
    start_v = 3'b000; we_v = 3'b000;
    for (int i = 0; i < 3; i++) begin lat[i] = 0; pulses[i] = 0; end
    for (int c = 1; c <= 16; c++) begin
      @(posedge clk);
      #1;
      if (c == 1) begin
        for (int i = 0; i < 3; i++)
          chk($sformatf("%s ready c1 u%0d", tag, i), ready_v[i], (smask[i] && ex[i] > 1) ? 64'd0 : 64'd1);
        if (smask[0] && n > 4'd1) chk({tag, " mid-state u0"}, dout[0], mid0[wsel*64 +: 64]);
      end
      for (int i = 0; i < 3; i++) begin
        if (done_v[i]) begin
          pulses[i]++;
          if (lat[i] == 0) lat[i] = c;
        end
      end
    end
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s latency u%0d", tag, i), lat[i], ex[i]);
      chk($sformatf("%s done pulses u%0d", tag, i), pulses[i], smask[i] ? 64'd1 : 64'd0);
      if (smask[i]) mdl[i] = model_rounds(mdl[i], 12 - int'(n), int'(n));
    end
    check_all_words(tag);
  endtask

  initial begin
    logic [3:0] badv [3];
    logic [319:0] pre;
    int lat, pulses;
    badv[0] = 4'd0; badv[1] = 4'd13; badv[2] = 4'd15;
    for (int i = 0; i < 3; i++) mdl[i] = '0;

    // Reset state.
    #3;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst ready u%0d", i), ready_v[i], 64'd1);
      chk($sformatf("rst done u%0d", i), done_v[i], 64'd0);
      chk($sformatf("rst err u%0d", i), err_v[i], 64'd0);
    end
    for (int s = 0; s < 5; s++) begin
      word_sel = 3'(s);
      #1;
      for (int i = 0; i < 3; i++) chk($sformatf("rst word u%0d w%0d", i, s), dout[i], 64'd0);
    end
    @(negedge clk);
    rst = 1'b0;

    // p12 on the zero state: latencies 12 / 4 / 3.
    start_and_wait("p12_zero", 3'b111, 4'd12, 12, 4, 3, 3'b000, 3'd0, 64'd0);

    // Load a pattern; last word written together with a p6 start on u1 and u4.
    write_word(3'b111, 3'd0, 64'h0123456789abcdef, 1'b0);
    write_word(3'b111, 3'd1, 64'hfedcba9876543210, 1'b0);
    write_word(3'b111, 3'd2, 64'h8000000000000001, 1'b0);
    write_word(3'b111, 3'd3, 64'h00000000ffffffff, 1'b0);
    start_and_wait("p6", 3'b101, 4'd6, 6, 0, 2, 3'b111, 3'd4, 64'h5a5a5a5a12345678);

    // p8 on the UNROLL=3 engine: 3+3+2 rounds.
    start_and_wait("p8_u3", 3'b010, 4'd8, 0, 3, 0, 3'b000, 3'd2, 64'd0);

    // Rejected starts: err pulse, still ready, state unchanged.
    for (int b = 0; b < 3; b++) begin
      @(negedge clk);
      start_v = 3'b111; rounds = badv[b];
      @(posedge clk);
      #1;
      start_v = 3'b000;
      chk($sformatf("bad%0d err", badv[b]), err_v, 64'd7);
      chk($sformatf("bad%0d ready", badv[b]), ready_v, 64'd7);
      chk($sformatf("bad%0d done", badv[b]), done_v, 64'd0);
      @(posedge clk);
      #1;
      chk($sformatf("bad%0d err clear", badv[b]), err_v, 64'd0);
      chk($sformatf("bad%0d ready after", badv[b]), ready_v, 64'd7);
    end
    check_all_words("after_bad");

    // Writes and starts during PERM are ignored.
    @(negedge clk);
    start_v = 3'b001; rounds = 4'd12;
    pre = mdl[0];
    @(posedge clk);
    #1;
    rounds = 4'd3; word_sel = 3'd2; data = 64'hffffffffffffffff; we_v = 3'b001;
    lat = 0; pulses = 0;
    for (int c = 1; c <= 16; c++) begin
      @(posedge clk);
      #1;
      if (c == 3) begin start_v = 3'b000; we_v = 3'b000; end
      if (done_v[0]) begin
        pulses++;
        if (lat == 0) lat = c;
      end
    end
    chk("perm_write latency", lat, 64'd12);
    chk("perm_write pulses", pulses, 64'd1);
    mdl[0] = model_rounds(pre, 0, 12);
    check_all_words("perm_write");

    // XOR write in IDLE: A5.. ^ 0F.. = AA..
    write_word(3'b001, 3'd2, 64'ha5a5a5a5a5a5a5a5, 1'b0);
    write_word(3'b001, 3'd2, 64'h0f0f0f0f0f0f0f0f, 1'b1);
    word_sel = 3'd2;
    #1;
    chk("xor_write w2", dout[0], 64'haaaaaaaaaaaaaaaa);
    // Write to index 5 is discarded.
    write_word(3'b111, 3'd5, 64'hdeadbeefcafef00d, 1'b0);
    check_all_words("xor_and_w5");

    // Reset during the 4th PERM cycle of a p12 run.
    @(negedge clk);
    start_v = 3'b001; rounds = 4'd12;
    @(posedge clk);
    #1;
    start_v = 3'b000;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst ready", ready_v, 64'd7);
    chk("midrst done", done_v, 64'd0);
    chk("midrst err", err_v, 64'd0);
    for (int s = 0; s < 5; s++) begin
      word_sel = 3'(s);
      #1;
      for (int i = 0; i < 3; i++) chk($sformatf("midrst u%0d w%0d", i, s), dout[i], 64'd0);
    end
    for (int i = 0; i < 3; i++) mdl[i] = '0;
    @(posedge clk);
    @(negedge clk);
    // First edge after release behaves as a normal IDLE cycle.
    rst = 1'b0; we_v = 3'b111; word_sel = 3'd1; data = 64'h1122334455667788;
    @(posedge clk);
    #1;
    we_v = 3'b000;
    for (int i = 0; i < 3; i++) mdl[i][127:64] = 64'h1122334455667788;
    chk("post_rst write u0", dout[0], 64'h1122334455667788);
    pulses = 0;
    for (int c = 0; c < 14; c++) begin
      @(posedge clk);
      #1;
      if (done_v != 3'b000) pulses++;
    end
    chk("post_rst no done", pulses, 64'd0);
    chk("post_rst ready", ready_v, 64'd7);
    check_all_words("post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
